// File: rtl/adc_pkg.sv
// ============================================================================
// adc_pkg : shared state encoding and default frame geometry for adc_spi_rx
// Revision : 1.0
// ============================================================================
`default_nettype none

package adc_pkg;

   localparam int DEF_BITS   = 16;
   localparam int DEF_DATA_W = 12;
   localparam int DEF_QUIET  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
// edge_det : one-clk rise/fall strobes for a level generated in the clk domain
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_d <= 1'b0;
      end else begin
         sig_d <= sig;
      end
   end

   assign rise = sig & ~sig_d;
   assign fall = ~sig & sig_d;

endmodule

`default_nettype wire

// File: rtl/adc_spi_rx.sv
// ============================================================================
// adc_spi_rx : continuous SPI ADC frame receiver; sclk is treated as data
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_spi_rx
   import adc_pkg::*;
#(
   parameter int BITS   = DEF_BITS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int QUIET  = DEF_QUIET
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              sdata,
   output logic              cs,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(BITS + 1);
   localparam int QW    = $clog2(QUIET + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITS - 1);
   localparam logic [QW-1:0]    QUIET_MAX = QW'(QUIET);

   state_t            state;
   state_t            next_state;
   logic              rise;
   logic              fall;
   logic [QW-1:0]     quiet_cnt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [BITS-1:0]   shreg;
   logic              lead_nz;
   logic              cs_nxt;
   logic              start;
   logic              capture;

   edge_det u_edge_det (
      .clk  (clk),
      .rst  (rst),
      .sig  (sclk),
      .rise (rise),
      .fall (fall)
   );

   // A frame with no header bits can never be flagged as malformed.
   generate
      if (BITS > DATA_W) begin : g_lead
         assign lead_nz = |shreg[BITS-1:DATA_W];
      end else begin : g_no_lead
         assign lead_nz = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (fall && (quiet_cnt == QUIET_MAX)) next_state = SHIFT;
         SHIFT:   if (rise && (bit_cnt == BIT_LAST))    next_state = DONE;
         DONE:    if (fall)                             next_state = IDLE;
         default:                                       next_state = IDLE;
      endcase
   end

   always_comb begin
      cs_nxt  = 1'b1;
      start   = 1'b0;
      capture = 1'b0;
      case (state)
         IDLE: begin
            cs_nxt = (next_state == IDLE);
            start  = (next_state == SHIFT);
         end
         SHIFT: begin
            cs_nxt = 1'b0;
         end
         DONE: begin
            cs_nxt  = (next_state == IDLE);
            capture = (next_state == IDLE);
         end
         default: begin
            cs_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs         <= 1'b1;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cs         <= cs_nxt;
         data_valid <= capture;
         if (capture) begin
            data      <= shreg[DATA_W-1:0];
            frame_err <= lead_nz;
         end
      end
   end

   // Quiet count only advances while idle and saturates; a new gap starts at frame end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quiet_cnt <= '0;
      end else if (capture) begin
         quiet_cnt <= '0;
      end else if ((state == IDLE) && rise && (quiet_cnt != QUIET_MAX)) begin
         quiet_cnt <= quiet_cnt + QW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (start) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if ((state == SHIFT) && rise) begin
         bit_cnt <= bit_cnt + CNT_W'(1);
         shreg   <= {shreg[BITS-2:0], sdata};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_rx.sv
// ============================================================================
// tb_adc_spi_rx : ADC word source, sclk generator and frame scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_spi_rx;

   localparam int BITS   = 16;
   localparam int DATA_W = 12;
   localparam int QUIET  = 2;
   localparam int HALF   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              sclk;
   logic              sdata;
   logic              cs;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              frame_err;

   always #5 clk = ~clk;

   adc_spi_rx #(
      .BITS   (BITS),
      .DATA_W (DATA_W),
      .QUIET  (QUIET)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .sdata      (sdata),
      .cs         (cs),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err)
   );

   typedef struct {
      logic [15:0] word;
      logic [11:0] exp_data;
      logic        exp_err;
   } vec_t;

   int          vectors     = 0;
   int          miscompares = 0;

   logic [15:0] word_q[$];
   logic [15:0] exp_q[$];
   logic        sclk_run = 1'b1;
   logic [15:0] cur_word = '0;
   int          bit_idx = 0;
   int          div = 0;
   int          cyc = 0;
   int          last_fall_cyc = -100;
   logic        gen_prev_cs = 1'b1;

   int          rises_low = 0;
   int          rises_high = 0;
   logic        mon_sclk = 1'b0;
   logic        mon_cs = 1'b1;
   logic        mon_dv = 1'b0;
   logic        mon_rst_ok = 1'b0;
   logic [11:0] last_data = '0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ADC model: presents the MSB when selected, advances on each sclk fall.
   initial begin
      sclk  = 1'b0;
      sdata = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (gen_prev_cs && !cs) begin
            cur_word = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
            exp_q.push_back(cur_word);
            bit_idx = BITS - 1;
            sdata   = cur_word[bit_idx];
         end
         gen_prev_cs = cs;
         if (sclk_run) begin
            div++;
            if (div == HALF) begin
               div  = 0;
               sclk = ~sclk;
               if (!sclk) begin
                  last_fall_cyc = cyc;
                  if (!cs && bit_idx > 0) begin
                     bit_idx--;
                     sdata = cur_word[bit_idx];
                  end
               end
            end
         end
      end
   end

   // Scoreboard and protocol monitor.
   always @(negedge clk) begin
      if (!rst) begin
         check("reset_cs", cs, 1);
         check("reset_data", data, 0);
         check("reset_valid", data_valid, 0);
         check("reset_err", frame_err, 0);
         rises_low  = 0;
         rises_high = 0;
         last_data  = '0;
         last_err   = 1'b0;
         mon_rst_ok = 1'b0;
      end else begin
         if (sclk && !mon_sclk) begin
            if (cs) rises_high++;
            else    rises_low++;
         end
         if (mon_cs && !cs) begin
            check("quiet_rises", rises_high, QUIET);
            rises_high = 0;
         end
         if (!mon_cs && cs && mon_rst_ok)
            check("valid_on_cs_release", data_valid, 1);
         if (data_valid) begin
            logic [15:0] w;
            check("valid_latency", cyc - last_fall_cyc, 1);
            check("rises_per_frame", rises_low, BITS);
            check("valid_width", mon_dv, 0);
            check("pending_frame", exp_q.size() > 0, 1);
            rises_low = 0;
            if (exp_q.size() > 0) begin
               w         = exp_q.pop_front();
               last_data = w[11:0];
               last_err  = |w[15:12];
               check("sb_data", data, last_data);
               check("sb_err", frame_err, last_err);
            end
         end else begin
            check("data_hold", data, last_data);
            check("err_hold", frame_err, last_err);
         end
         mon_rst_ok = 1'b1;
      end
      mon_sclk = sclk;
      mon_cs   = cs;
      mon_dv   = data_valid;
   end

   task automatic wait_valid(input int budget, output bit got);
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         if (data_valid) got = 1'b1;
      end
      check("valid_timeout", got, 1);
   endtask

   task automatic release_reset();
      do begin
         @(posedge clk);
         #2;
      end while (sclk);
      rst = 1'b1;
   endtask

   vec_t        tbl[9];
   logic [15:0] rnd[10];

   initial begin
      bit got;
      bit hit;
      rst = 1'b0;

      tbl[0] = '{16'h0ABC, 12'hABC, 1'b0};
      tbl[1] = '{16'h0FFF, 12'hFFF, 1'b0};
      tbl[2] = '{16'h0001, 12'h001, 1'b0};
      tbl[3] = '{16'h8123, 12'h123, 1'b1};
      tbl[4] = '{16'h0123, 12'h123, 1'b0};
      tbl[5] = '{16'h0555, 12'h555, 1'b0};
      tbl[6] = '{16'hF000, 12'h000, 1'b1};
      tbl[7] = '{16'h1FFF, 12'hFFF, 1'b1};
      tbl[8] = '{16'h0000, 12'h000, 1'b0};

      repeat (5) @(negedge clk);
      foreach (tbl[i]) word_q.push_back(tbl[i].word);
      release_reset();

      for (int i = 0; i < 9; i++) begin
         wait_valid(400, got);
         if (got) begin
            check("vec_data", data, tbl[i].exp_data);
            check("vec_err", frame_err, tbl[i].exp_err);
         end
      end

      for (int i = 0; i < 10; i++) begin
         rnd[i] = 16'($urandom);
         word_q.push_back(rnd[i]);
      end
      for (int i = 0; i < 10; i++) begin
         wait_valid(400, got);
         if (got) begin
            check("rnd_data", data, rnd[i][11:0]);
            check("rnd_err", frame_err, |rnd[i][15:12]);
         end
      end

      // sclk frozen high mid-frame: nothing may move until it resumes.
      word_q.push_back(16'h0A5A);
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
         @(negedge clk);
         if (!cs && rises_low >= 5 && sclk && div <= 1) hit = 1'b1;
      end
      check("freeze_reach", hit, 1);
      sclk_run = 1'b0;
      repeat (100) begin
         @(negedge clk);
         check("freeze_cs", cs, 0);
         check("freeze_valid", data_valid, 0);
      end
      sclk_run = 1'b1;
      wait_valid(400, got);
      if (got) begin
         check("freeze_data", data, 12'hA5A);
         check("freeze_err", frame_err, 0);
      end

      // Reset after the 8th rise of a frame aborts it.
      word_q.push_back(16'h0F0F);
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
         @(negedge clk);
         if (!cs && rises_low == 8) hit = 1'b1;
      end
      check("abort_reach", hit, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_cs", cs, 1);
      check("abort_data", data, 0);
      check("abort_valid", data_valid, 0);
      word_q.delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      word_q.push_back(16'h0555);
      release_reset();
      wait_valid(400, got);
      if (got) begin
         check("post_abort_data", data, 12'h555);
         check("post_abort_err", frame_err, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 Parameter BITS, default 16, SHALL set serial frame length in sclk periods.
REQ-002 Parameter DATA_W, default 12, SHALL set conversion result width (LSB-aligned, last DATA_W bits of frame).
REQ-003 Parameter QUIET, default 2, SHALL set minimum sclk rising edges with cs high between frames.
REQ-004 clk  input  1  system clock, 100 MHz; sole clock of the block.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 sclk  input  1  divided serial clock level from the clock divider, generated in the clk domain; sampled as data, never used as a clock.
REQ-007 sdata  input  1  serial data from ADC, valid around sclk rising edge.
REQ-008 cs  output  1  ADC chip select, active-low, registered.
REQ-009 data  output  DATA_W  last completed conversion result, registered.
REQ-010 data_valid  output  1  one-clk pulse when data updates.
REQ-011 frame_err  output  1  registered; high when the leading BITS-DATA_W bits of the last frame were not all zero.

Function
REQ-012 Block SHALL register sclk once (sclk_d) and derive rise = sclk & ~sclk_d, fall = ~sclk & sclk_d, each one clk wide.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: cs=1; quiet counter SHALL increment on each rise, saturating at QUIET.
REQ-015 IDLE -> SHIFT on the first fall with quiet counter == QUIET; cs SHALL go 0 on the clk following that fall; bit counter and shift register cleared.
REQ-016 SHIFT: on each rise, shift register SHALL shift left by one with sdata entering bit 0, bit counter +1.
REQ-017 SHIFT -> DONE on the rise that captures bit BITS (counter reaches BITS).
REQ-018 DONE -> IDLE on the next fall; on that same transition cs=1, data <= shift[DATA_W-1:0], frame_err <= |shift[BITS-1:DATA_W], data_valid=1 for exactly one clk; quiet counter cleared.
REQ-019 data and frame_err SHALL hold their values between updates; data_valid SHALL be 0 in all other cycles.
REQ-020 rise and fall in same clk cannot occur; no priority rule required; sclk static SHALL leave FSM frozen in current state with outputs held.
REQ-021 Result latency: data_valid SHALL assert 1 clk after the sclk falling edge following the BITS-th rising edge.
REQ-022 Frames SHALL repeat continuously; no start/enable input.
REQ-023 Counters SHALL be sized $clog2(BITS+1) and $clog2(QUIET+1); no wrap-around permitted (saturate/clear only).

Reset
REQ-024 While rst=0: state IDLE, cs=1, data=0, data_valid=0, frame_err=0, sclk_d=0, all counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (cs=1 asynchronously), discard partial data, and require QUIET rises after release before next frame.

Structure
REQ-026 Shared package adc_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default BITS/DATA_W/QUIET constants.
REQ-027 Edge detection SHALL be one sub-module, edge_det (in: clk, rst, sig; out: rise, fall); remainder in adc_spi_rx.

Verification (bench drives sclk with half-period 4 clk; ADC model shifts a 16-bit word MSB-first, updating sdata on sclk fall)
REQ-028 Reset release, word 16'h0ABC -> cs low after 2 quiet rises, data=12'hABC, data_valid one clk, frame_err=0.
REQ-029 Word 16'h0FFF then 16'h0001 back-to-back -> data 12'hFFF then 12'h001, exactly 2 rises with cs=1 between frames, two single-clk valid pulses.
REQ-030 Word 16'h8123 -> data=12'h123, frame_err=1; next frame 16'h0123 -> frame_err=0.
REQ-031 rst low after 8th rise of a frame -> cs=1 same cycle, data stays 0, no data_valid; after release, next full frame 16'h0555 -> data=12'h555.
REQ-032 sclk held high for 100 clk mid-frame -> no state change, cs stays 0, no spurious valid; frame completes correctly once sclk resumes.
REQ-033 Count check: exactly 16 rises with cs=0 per frame; data_valid asserted exactly 1 clk after the cs-releasing fall.
